decoder_multidigito: RTL and testbench

Parametrised successor to the single-digit BCD-to-7-segment decoder. Takes an unsigned binary value and converts it sequentially to BCD (shift-and-add-3, one bit per clock). Drives N_DIGITOS registered 7-segment patterns in static mode, one display per digit on the board. Adds a start/busy/done handshake, overflow indication, leading-zero blanking and selectable segment polarity.

---
 rtl/decoder_pkg.sv | 36 +++
 rtl/deco_7seg.sv | 40 ++++
 rtl/decoder_multidigito.sv | 164 ++++++++++++++++
 tb/tb_decoder_multidigito.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and constants for the multi-digit 7-segment decoder.
//   estado_t     : controller states
//   SEG_*        : active-high segment patterns, bit order {g,f,e,d,c,b,a}
//   pot10(n)     : 10^n, used for elaboration-time range limits
package decoder_pkg;

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        CONVIERTE = 2'd1,
        SALIDA    = 2'd2
    } estado_t;

    localparam logic [6:0] SEG_0      = 7'h3F;
    localparam logic [6:0] SEG_1      = 7'h06;
    localparam logic [6:0] SEG_2      = 7'h5B;
    localparam logic [6:0] SEG_3      = 7'h4F;
    localparam logic [6:0] SEG_4      = 7'h66;
    localparam logic [6:0] SEG_5      = 7'h6D;
    localparam logic [6:0] SEG_6      = 7'h7D;
    localparam logic [6:0] SEG_7      = 7'h07;
    localparam logic [6:0] SEG_8      = 7'h7F;
    localparam logic [6:0] SEG_9      = 7'h6F;
    localparam logic [6:0] SEG_GUION  = 7'h40;
    localparam logic [6:0] SEG_BLANCO = 7'h00;

    // 10^n in 32 bits; large enough for up to 9 digits.
    function automatic logic [31:0] pot10(input int unsigned n);
        logic [31:0] r;
        r = 32'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/deco_7seg.sv
// One-digit BCD to 7-segment decoder (combinational).
//   digito      : BCD nibble; 10..15 decode to a dash
//   blanco      : 1 forces the digit dark
//   segmentos_c : segment pattern {g,f,e,d,c,b,a}, polarity set by ACTIVO_BAJO
module deco_7seg
    import decoder_pkg::*;
#(
    parameter bit ACTIVO_BAJO = 1'b1
) (
    input  logic [3:0] digito,
    input  logic       blanco,
    output logic [6:0] segmentos_c
);

    logic [6:0] seg_alto;

    // Decode in active-high form, then apply output polarity.
    always_comb begin
        seg_alto = SEG_GUION;
        if (blanco) begin
            seg_alto = SEG_BLANCO;
        end else begin
            case (digito)
                4'd0:    seg_alto = SEG_0;
                4'd1:    seg_alto = SEG_1;
                4'd2:    seg_alto = SEG_2;
                4'd3:    seg_alto = SEG_3;
                4'd4:    seg_alto = SEG_4;
                4'd5:    seg_alto = SEG_5;
                4'd6:    seg_alto = SEG_6;
                4'd7:    seg_alto = SEG_7;
                4'd8:    seg_alto = SEG_8;
                4'd9:    seg_alto = SEG_9;
                default: seg_alto = SEG_GUION;
            endcase
        end
        segmentos_c = ACTIVO_BAJO ? ~seg_alto : seg_alto;
    end

endmodule

// File: rtl/decoder_multidigito.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// driving N_DIGITOS static 7-segment displays.
//   clk, rst_n        : clock (rising edge), synchronous active-low reset
//   entrada_bin       : unsigned value, captured when inicio is accepted
//   inicio            : start request, honoured only when idle
//   blanqueo_ceros    : 1 = blank leading zeros, captured with entrada_bin
//   ocupado           : conversion in progress (through the listo cycle)
//   listo             : one-cycle pulse, new results valid this cycle
//   desborde          : last value did not fit in N_DIGITOS digits
//   salida_segmentos  : digit i at [7i+6:7i], digit 0 least significant
module decoder_multidigito
    import decoder_pkg::*;
#(
    parameter int unsigned N_DIGITOS   = 4,
    parameter int unsigned ANCHO_BIN   = 14,
    parameter bit          ACTIVO_BAJO = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ANCHO_BIN-1:0]   entrada_bin,
    input  logic                   inicio,
    input  logic                   blanqueo_ceros,
    output logic                   ocupado,
    output logic                   listo,
    output logic                   desborde,
    output logic [7*N_DIGITOS-1:0] salida_segmentos
);

    localparam int unsigned ANCHO_BCD = 4 * N_DIGITOS;
    localparam int unsigned ANCHO_SEG = 7 * N_DIGITOS;
    localparam int unsigned ANCHO_CNT = $clog2(ANCHO_BIN + 1);
    localparam int unsigned ANCHO_CMP = (ANCHO_BIN > 32) ? ANCHO_BIN : 32;
    localparam logic [31:0] MAX       = pot10(N_DIGITOS) - 32'd1;
    localparam logic [6:0]  SEG_APAGADO = ACTIVO_BAJO ? ~SEG_BLANCO : SEG_BLANCO;

    estado_t                          estado;
    estado_t                          estado_sig;
    logic                             acepta_c;
    logic [ANCHO_BIN-1:0]             bin_q;
    logic [ANCHO_BCD-1:0]             bcd_q;
    logic [ANCHO_BCD-1:0]             bcd_aj_c;
    logic [ANCHO_BCD-1:0]             bcd_sig_c;
    logic [ANCHO_CNT-1:0]             cnt_q;
    logic                             blanqueo_q;
    logic                             desborde_q;
    logic                             desborde_c;
    logic [N_DIGITOS-1:0][3:0]        digito_c;
    logic [N_DIGITOS-1:0]             blanco_c;
    logic                             cero_arriba;
    logic [ANCHO_SEG-1:0]             seg_c;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado <= REPOSO;
        end else begin
            estado <= estado_sig;
        end
    end

    // Next-state logic; counter value 1 marks the final shift.
    always_comb begin
        estado_sig = estado;
        acepta_c   = 1'b0;
        case (estado)
            REPOSO: begin
                if (inicio) begin
                    acepta_c   = 1'b1;
                    estado_sig = CONVIERTE;
                end
            end
            CONVIERTE: begin
                if (cnt_q == ANCHO_CNT'(1)) begin
                    estado_sig = SALIDA;
                end
            end
            SALIDA:  estado_sig = REPOSO;
            default: estado_sig = REPOSO;
        endcase
    end

    // Add-3 correction on every nibble >= 5, then shift in the next binary MSB;
    // the carry out of the top nibble is dropped (covered by desborde).
    always_comb begin
        bcd_aj_c = '0;
        for (int i = 0; i < int'(N_DIGITOS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_aj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end else begin
                bcd_aj_c[4*i +: 4] = bcd_q[4*i +: 4];
            end
        end
        bcd_sig_c = ANCHO_BCD'({bcd_aj_c, bin_q[ANCHO_BIN-1]});
    end

    // Range check on the value being captured.
    assign desborde_c = ANCHO_CMP'(entrada_bin) > ANCHO_CMP'(MAX);

    // Leading-zero blanking chain, scanned from the most significant digit.
    // On overflow every digit is fed 4'hF, which the decoder shows as a dash.
    always_comb begin
        cero_arriba = 1'b1;
        blanco_c    = '0;
        digito_c    = '0;
        for (int i = int'(N_DIGITOS) - 1; i >= 0; i--) begin
            cero_arriba = cero_arriba & (bcd_q[4*i +: 4] == 4'd0);
            blanco_c[i] = blanqueo_q & ~desborde_q & cero_arriba & (i != 0);
            digito_c[i] = desborde_q ? 4'hF : bcd_q[4*i +: 4];
        end
    end

    for (genvar g = 0; g < int'(N_DIGITOS); g++) begin : g_deco
        deco_7seg #(
            .ACTIVO_BAJO (ACTIVO_BAJO)
        ) u_deco (
            .digito      (digito_c[g]),
            .blanco      (blanco_c[g]),
            .segmentos_c (seg_c[7*g +: 7])
        );
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ocupado          <= 1'b0;
            listo            <= 1'b0;
            desborde         <= 1'b0;
            salida_segmentos <= {N_DIGITOS{SEG_APAGADO}};
            bin_q            <= '0;
            bcd_q            <= '0;
            cnt_q            <= '0;
            blanqueo_q       <= 1'b0;
            desborde_q       <= 1'b0;
        end else begin
            listo <= 1'b0;
            case (estado)
                REPOSO: begin
                    if (acepta_c) begin
                        ocupado    <= 1'b1;
                        bin_q      <= entrada_bin;
                        bcd_q      <= '0;
                        cnt_q      <= ANCHO_CNT'(ANCHO_BIN);
                        blanqueo_q <= blanqueo_ceros;
                        desborde_q <= desborde_c;
                    end else begin
                        ocupado <= 1'b0;
                    end
                end
                CONVIERTE: begin
                    bcd_q <= bcd_sig_c;
                    bin_q <= bin_q << 1;
                    cnt_q <= cnt_q - ANCHO_CNT'(1);
                end
                SALIDA: begin
                    salida_segmentos <= seg_c;
                    desborde         <= desborde_q;
                    listo            <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_multidigito.sv
// Bench for decoder_multidigito: arithmetic reference model compared every
// cycle, plus directed conversions with hand-computed segment patterns.
module tb_decoder_multidigito;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 14;
    localparam bit          AB = 1'b1;
    localparam int unsigned WS = 7 * N;
    localparam int          LAT = W + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  entrada_bin;
    logic          inicio;
    logic          blanqueo_ceros;
    logic          ocupado;
    logic          listo;
    logic          desborde;
    logic [WS-1:0] salida_segmentos;

    int n_tests = 0;
    int n_fail  = 0;

    decoder_multidigito #(
        .N_DIGITOS   (N),
        .ANCHO_BIN   (W),
        .ACTIVO_BAJO (AB)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .entrada_bin      (entrada_bin),
        .inicio           (inicio),
        .blanqueo_ceros   (blanqueo_ceros),
        .ocupado          (ocupado),
        .listo            (listo),
        .desborde         (desborde),
        .salida_segmentos (salida_segmentos)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WS-1:0] act, input logic [WS-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference segment pattern from decimal arithmetic.
    function automatic logic [6:0] codigo(input int d);
        logic [6:0] tab [0:10];
        logic [6:0] c;
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40};
        c = tab[d];
        return AB ? ~c : c;
    endfunction

    function automatic logic [WS-1:0] esperado(input int v, input bit bl);
        logic [WS-1:0] r;
        int p;
        int lim;
        lim = 1;
        for (int i = 0; i < int'(N); i++) lim = lim * 10;
        r = '0;
        p = 1;
        for (int i = 0; i < int'(N); i++) begin
            if (v > lim - 1)
                r[7*i +: 7] = codigo(10);
            else if (bl && i > 0 && v < p)
                r[7*i +: 7] = AB ? 7'h7F : 7'h00;
            else
                r[7*i +: 7] = codigo((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic bit desb_ref(input int v);
        int lim;
        lim = 1;
        for (int i = 0; i < int'(N); i++) lim = lim * 10;
        return v > lim - 1;
    endfunction

    // Reference model: counts edges from acceptance to the result.
    logic          m_ocup, m_listo, m_desb, p_desb;
    logic [WS-1:0] m_seg, p_seg;
    int            m_cnt;
    bit            m_valid = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ocup  = 1'b0;
            m_listo = 1'b0;
            m_desb  = 1'b0;
            m_seg   = {N{AB ? 7'h7F : 7'h00}};
            m_cnt   = 0;
        end else begin
            m_listo = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_listo = 1'b1;
                    m_seg   = p_seg;
                    m_desb  = p_desb;
                end
            end else if (inicio) begin
                m_ocup = 1'b1;
                m_cnt  = LAT;
                p_seg  = esperado(int'(entrada_bin), blanqueo_ceros);
                p_desb = desb_ref(int'(entrada_bin));
            end else begin
                m_ocup = 1'b0;
            end
        end
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("ocupado", WS'(ocupado), WS'(m_ocup));
            check("listo", WS'(listo), WS'(m_listo));
            check("desborde", WS'(desborde), WS'(m_desb));
            check("segmentos", salida_segmentos, m_seg);
        end
    end

    task automatic esperar_listo(input string tag, input int ya);
        int ciclos;
        ciclos = ya;
        while (!listo && ciclos < 40) begin
            @(negedge clk);
            ciclos++;
        end
        check({tag, "_latencia"}, WS'(ciclos), WS'(LAT));
    endtask

    task automatic convertir(input int v, input bit bl, input logic [WS-1:0] exp_seg,
                             input bit exp_desb, input string tag);
        entrada_bin    = W'(v);
        blanqueo_ceros = bl;
        inicio         = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        esperar_listo(tag, 0);
        check({tag, "_seg"}, salida_segmentos, exp_seg);
        check({tag, "_desb"}, WS'(desborde), WS'(exp_desb));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded its time bound");
        $fatal(1, "timeout");
    end

    initial begin
        int nl;
        rst_n          = 1'b0;
        inicio         = 1'b1;
        entrada_bin    = W'(5);
        blanqueo_ceros = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_seg", salida_segmentos, 28'hFFFFFFF);
        check("rst_ocupado", WS'(ocupado), '0);
        check("rst_listo", WS'(listo), '0);
        check("rst_desb", WS'(desborde), '0);
        rst_n  = 1'b1;
        inicio = 1'b0;
        @(negedge clk);

        convertir(9999, 1'b0, {4{7'h10}}, 1'b0, "v9999");
        convertir(42, 1'b1, {7'h7F, 7'h7F, 7'h19, 7'h24}, 1'b0, "v42_blank");
        convertir(42, 1'b0, {7'h40, 7'h40, 7'h19, 7'h24}, 1'b0, "v42");
        convertir(0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0, "v0_blank");
        convertir(10000, 1'b1, {4{7'h3F}}, 1'b1, "v10000");
        convertir(305, 1'b1, {7'h7F, 7'h30, 7'h40, 7'h12}, 1'b0, "v305");

        // Start request while busy is dropped; then a back-to-back start.
        entrada_bin    = W'(1234);
        blanqueo_ceros = 1'b0;
        inicio         = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        repeat (4) @(negedge clk);
        entrada_bin = W'(5678);
        inicio      = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        esperar_listo("v1234", 5);
        check("v1234_seg", salida_segmentos, {7'h79, 7'h24, 7'h30, 7'h19});
        entrada_bin = W'(5678);
        inicio      = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        check("b2b_ocupado", WS'(ocupado), WS'(1));
        esperar_listo("v5678", 0);
        check("v5678_seg", salida_segmentos, {7'h12, 7'h02, 7'h78, 7'h00});
        @(negedge clk);

        convertir(16383, 1'b0, {4{7'h3F}}, 1'b1, "v16383");

        // Reset in the middle of a conversion.
        entrada_bin    = W'(777);
        blanqueo_ceros = 1'b1;
        inicio         = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_seg", salida_segmentos, 28'hFFFFFFF);
        check("midrst_ocupado", WS'(ocupado), '0);
        check("midrst_desb", WS'(desborde), '0);
        rst_n = 1'b1;
        nl = 0;
        repeat (20) begin
            @(negedge clk);
            if (listo) nl++;
        end
        check("midrst_sin_listo", WS'(nl), '0);
        convertir(777, 1'b1, {7'h7F, 7'h78, 7'h78, 7'h78}, 1'b0, "v777");

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
